// File: rtl/register_bank_ir_pkg.sv
// Shared definitions for the register bank: sweep state encoding and an
// address-width helper.
package register_bank_ir_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } bank_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/register_bank_ir_rport.sv
// One read port: word select, write-through bypass and tri-state output
// driver onto the shared read bus.
module register_bank_ir_rport
  import register_bank_ir_pkg::*;
#(
  parameter int NrOfBits  = 8,
  parameter int NrOfWords = 4,
  parameter int Bypass    = 1,
  localparam int AddrBits = clog2(NrOfWords)
) (
  input  logic [NrOfWords-1:0][NrOfBits-1:0] words,
  input  logic [AddrBits-1:0]                raddr,
  input  logic [AddrBits-1:0]                waddr,
  input  logic [NrOfBits-1:0]                D,
  input  logic                               wr_fire,
  input  logic                               cs,
  output logic [NrOfBits-1:0]                Q
);

  localparam bit UseBypass = (Bypass != 0);

  logic                hit;
  logic [NrOfBits-1:0] data;

  // Bypass only forwards a write that will actually land on this edge.
  assign hit  = UseBypass && wr_fire && (waddr == raddr);
  assign data = hit ? D : words[raddr];
  assign Q    = cs ? {NrOfBits{1'bz}} : data;

endmodule

// File: rtl/register_bank_ir.sv
// Multi-word register bank with tick-qualified writes, synchronous preset,
// a sequenced clear sweep and two tri-statable read ports.
module register_bank_ir
  import register_bank_ir_pkg::*;
#(
  parameter int NrOfBits    = 8,
  parameter int NrOfWords   = 4,
  parameter int ActiveLevel = 1,
  parameter int Bypass      = 1,
  localparam int AddrBits   = clog2(NrOfWords)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                we,
  input  logic [AddrBits-1:0] waddr,
  input  logic [NrOfBits-1:0] D,
  input  logic                pre,
  input  logic                clr,
  input  logic [AddrBits-1:0] raddr_a,
  input  logic [AddrBits-1:0] raddr_b,
  input  logic                cs,
  output logic [NrOfBits-1:0] Q_a,
  output logic [NrOfBits-1:0] Q_b,
  output logic                valid_a,
  output logic                valid_b,
  output logic                busy,
  output logic                drop
);

  localparam logic [AddrBits-1:0] LastPtr = AddrBits'(NrOfWords - 1);
  localparam logic [AddrBits-1:0] OnePtr  = AddrBits'(1);

  logic                              clk_act;
  logic                              qt;
  logic                              wr_fire;
  bank_state_t                       state, nxt_state;
  logic [AddrBits-1:0]               ptr, nxt_ptr;
  logic [NrOfWords-1:0][NrOfBits-1:0] mem;
  logic [NrOfWords-1:0]              valid;

  // Falling-edge builds simply run every register off the inverted clock.
  assign clk_act = (ActiveLevel != 0) ? Clock : ~Clock;
  assign qt      = ClockEnable & Tick;
  assign wr_fire = we & qt & ~busy & ~pre;

  always_ff @(posedge clk_act or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= nxt_state;
      ptr   <= nxt_ptr;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    if (pre) begin
      nxt_state = IDLE;
      nxt_ptr   = '0;
    end else if (qt) begin
      case (state)
        IDLE: begin
          if (clr) begin
            nxt_state = SWEEP;
            nxt_ptr   = '0;
          end
        end
        SWEEP: begin
          if (ptr == LastPtr) begin
            nxt_state = IDLE;
            nxt_ptr   = '0;
          end else begin
            nxt_ptr = ptr + OnePtr;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_ptr   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == SWEEP);
  end

  // Storage: preset beats the sweep step, which beats a user write.
  always_ff @(posedge clk_act or posedge Reset) begin
    if (Reset) begin
      mem   <= '0;
      valid <= '0;
      drop  <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (pre) begin
        mem   <= '1;
        valid <= '1;
      end else if (qt) begin
        if (state == SWEEP) begin
          mem[ptr]   <= '0;
          valid[ptr] <= 1'b0;
          drop       <= we;
        end else if (we) begin
          mem[waddr]   <= D;
          valid[waddr] <= 1'b1;
        end
      end
    end
  end

  assign valid_a = valid[raddr_a];
  assign valid_b = valid[raddr_b];

  register_bank_ir_rport #(
    .NrOfBits (NrOfBits),
    .NrOfWords(NrOfWords),
    .Bypass   (Bypass)
  ) u_rport_a (
    .words  (mem),
    .raddr  (raddr_a),
    .waddr  (waddr),
    .D      (D),
    .wr_fire(wr_fire),
    .cs     (cs),
    .Q      (Q_a)
  );

  register_bank_ir_rport #(
    .NrOfBits (NrOfBits),
    .NrOfWords(NrOfWords),
    .Bypass   (Bypass)
  ) u_rport_b (
    .words  (mem),
    .raddr  (raddr_b),
    .waddr  (waddr),
    .D      (D),
    .wr_fire(wr_fire),
    .cs     (cs),
    .Q      (Q_b)
  );

endmodule

// File: tb/tb_register_bank_ir.sv
// Scoreboard bench for register_bank_ir: a rising-edge and a falling-edge
// instance share stimulus; expectations are queued and checked by a monitor.
module tb_register_bank_ir;

  localparam int SelQa   = 0;
  localparam int SelVa   = 1;
  localparam int SelQb   = 2;
  localparam int SelVb   = 3;
  localparam int SelBusy = 4;
  localparam int SelDrop = 5;
  localparam int SelQaN  = 6;
  localparam int SelVaN  = 7;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset, ClockEnable, Tick, we, pre, clr, cs;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [7:0] D;

  tri   [7:0] bus_a, bus_b;
  logic       valid_a, valid_b, busy, drop;
  wire  [7:0] q_a_n, q_b_n;
  logic       valid_a_n, valid_b_n, busy_n, drop_n;

  logic       drv_en  = 1'b0;
  logic [7:0] drv_val = 8'h00;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  always #5 Clock = ~Clock;

  // Another bus master; only legal while the bank's ports are released.
  assign bus_a = drv_en ? drv_val : 8'bz;
  assign bus_b = drv_en ? drv_val : 8'bz;

  register_bank_ir #(
    .NrOfBits(8), .NrOfWords(4), .ActiveLevel(1), .Bypass(1)
  ) u_dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .we(we), .waddr(waddr), .D(D), .pre(pre), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .cs(cs),
    .Q_a(bus_a), .Q_b(bus_b), .valid_a(valid_a), .valid_b(valid_b),
    .busy(busy), .drop(drop)
  );

  register_bank_ir #(
    .NrOfBits(8), .NrOfWords(4), .ActiveLevel(0), .Bypass(1)
  ) u_dut_n (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .we(we), .waddr(waddr), .D(D), .pre(pre), .clr(clr),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .cs(1'b0),
    .Q_a(q_a_n), .Q_b(q_b_n), .valid_a(valid_a_n), .valid_b(valid_b_n),
    .busy(busy_n), .drop(drop_n)
  );

  task automatic applyStimulus(input logic we_i, input logic [1:0] wa,
                               input logic [7:0] d, input logic pre_i,
                               input logic clr_i, input logic tick_i);
    we    = we_i;
    waddr = wa;
    D     = d;
    pre   = pre_i;
    clr   = clr_i;
    Tick  = tick_i;
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    scoreboard.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic cycle();
    @(posedge Clock);
    #2;
  endtask

  task automatic readAt(input logic [1:0] a, input logic [1:0] b);
    raddr_a = a;
    raddr_b = b;
  endtask

  initial begin
    forever begin
      @(sample_ev);
      while (scoreboard.size() > 0) begin
        exp_t       e;
        logic [7:0] act;
        e = scoreboard.pop_front();
        case (e.sel)
          SelQa:   act = bus_a;
          SelVa:   act = {7'd0, valid_a};
          SelQb:   act = bus_b;
          SelVb:   act = {7'd0, valid_b};
          SelBusy: act = {7'd0, busy};
          SelDrop: act = {7'd0, drop};
          SelQaN:  act = q_a_n;
          default: act = {7'd0, valid_a_n};
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    ClockEnable = 1'b1;
    cs = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    readAt(2'd0, 2'd3);
    repeat (2) @(posedge Clock);
    #2;
    Reset = 1'b0;

    checkOutput("reset_qa", SelQa, 8'h00);
    checkOutput("reset_va", SelVa, 8'h00);
    checkOutput("reset_qb", SelQb, 8'h00);
    checkOutput("reset_vb", SelVb, 8'h00);
    checkOutput("reset_busy", SelBusy, 8'h00);
    checkOutput("reset_drop", SelDrop, 8'h00);
    sample();

    applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 1'b1);
    readAt(2'd1, 2'd3);
    cycle();
    applyStimulus(1'b0, 2'd2, 8'hA5, 1'b0, 1'b0, 1'b0);
    readAt(2'd2, 2'd1);
    checkOutput("write_a5_q", SelQa, 8'hA5);
    checkOutput("write_a5_valid", SelVa, 8'h01);
    checkOutput("unwritten_q", SelQb, 8'h00);
    checkOutput("unwritten_valid", SelVb, 8'h00);
    sample();

    applyStimulus(1'b1, 2'd1, 8'h3C, 1'b0, 1'b0, 1'b0);
    readAt(2'd1, 2'd2);
    cycle();
    checkOutput("no_tick_q", SelQa, 8'h00);
    checkOutput("no_tick_valid", SelVa, 8'h00);
    sample();
    Tick = 1'b1;
    readAt(2'd1, 2'd1);
    checkOutput("bypass_qb", SelQb, 8'h3C);
    sample();
    cycle();
    applyStimulus(1'b0, 2'd1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkOutput("stored_3c", SelQa, 8'h3C);
    checkOutput("stored_3c_valid", SelVa, 8'h01);
    checkOutput("no_drop_idle", SelDrop, 8'h00);
    sample();

    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle();
    pre = 1'b0;
    readAt(2'd0, 2'd3);
    checkOutput("pre_q0", SelQa, 8'hFF);
    checkOutput("pre_v0", SelVa, 8'h01);
    checkOutput("pre_q3", SelQb, 8'hFF);
    checkOutput("pre_v3", SelVb, 8'h01);
    sample();
    cs = 1'b1;
    drv_en = 1'b1;
    drv_val = 8'h5A;
    checkOutput("cs_release_a", SelQa, 8'h5A);
    checkOutput("cs_release_b", SelQb, 8'h5A);
    checkOutput("cs_valid_a", SelVa, 8'h01);
    checkOutput("cs_valid_b", SelVb, 8'h01);
    sample();
    cs = 1'b0;
    drv_en = 1'b0;

    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle();
    readAt(2'd0, 2'd1);
    checkOutput("sweep_busy", SelBusy, 8'h01);
    checkOutput("sweep_wait_q0", SelQa, 8'hFF);
    sample();
    Tick = 1'b1;
    cycle();
    Tick = 1'b0;
    checkOutput("sweep_clr0_q", SelQa, 8'h00);
    checkOutput("sweep_clr0_v", SelVa, 8'h00);
    checkOutput("sweep_keep1_q", SelQb, 8'hFF);
    checkOutput("sweep_keep1_v", SelVb, 8'h01);
    sample();
    cycle();
    applyStimulus(1'b1, 2'd3, 8'h11, 1'b0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 2'd3, 8'h11, 1'b0, 1'b0, 1'b0);
    readAt(2'd1, 2'd3);
    checkOutput("drop_pulse", SelDrop, 8'h01);
    checkOutput("sweep_clr1_q", SelQa, 8'h00);
    checkOutput("drop_word_kept", SelQb, 8'hFF);
    sample();
    cycle();
    checkOutput("drop_cleared", SelDrop, 8'h00);
    sample();
    Tick = 1'b1;
    cycle();
    checkOutput("sweep_busy_3", SelBusy, 8'h01);
    sample();
    cycle();
    Tick = 1'b0;
    checkOutput("sweep_done_busy", SelBusy, 8'h00);
    checkOutput("sweep_clr3_q", SelQb, 8'h00);
    checkOutput("sweep_clr3_v", SelVb, 8'h00);
    sample();

    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle();
    clr = 1'b0;
    repeat (2) cycle();
    Tick = 1'b0;
    readAt(2'd2, 2'd1);
    checkOutput("mid_sweep_q2", SelQa, 8'hFF);
    checkOutput("mid_sweep_q1", SelQb, 8'h00);
    checkOutput("mid_sweep_busy", SelBusy, 8'h01);
    sample();
    Reset = 1'b1;
    checkOutput("async_reset_busy", SelBusy, 8'h00);
    checkOutput("async_reset_q2", SelQa, 8'h00);
    checkOutput("async_reset_v2", SelVa, 8'h00);
    sample();
    Reset = 1'b0;

    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle();
    clr = 1'b0;
    cycle();
    readAt(2'd0, 2'd3);
    pre = 1'b1;
    cycle();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_mid_busy", SelBusy, 8'h00);
    checkOutput("pre_mid_q0", SelQa, 8'hFF);
    checkOutput("pre_mid_v0", SelVa, 8'h01);
    sample();
    applyStimulus(1'b1, 2'd0, 8'h77, 1'b0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 2'd0, 8'h77, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_after_pre_q0", SelQa, 8'h77);
    checkOutput("idle_after_pre_drop", SelDrop, 8'h00);
    sample();

    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    @(negedge Clock);
    #2;
    applyStimulus(1'b1, 2'd2, 8'hC3, 1'b0, 1'b0, 1'b1);
    readAt(2'd0, 2'd0);
    @(posedge Clock);
    #1;
    we = 1'b0;
    readAt(2'd2, 2'd0);
    checkOutput("falling_rise_ignored_q", SelQaN, 8'h00);
    checkOutput("falling_rise_ignored_v", SelVaN, 8'h00);
    sample();
    we = 1'b1;
    readAt(2'd0, 2'd0);
    @(negedge Clock);
    #1;
    applyStimulus(1'b0, 2'd2, 8'hC3, 1'b0, 1'b0, 1'b0);
    readAt(2'd2, 2'd0);
    checkOutput("falling_capture_q", SelQaN, 8'hC3);
    checkOutput("falling_capture_v", SelVaN, 8'h01);
    sample();

    #5;
    if (scoreboard.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreboard.size());
      errors += scoreboard.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
